alu_issue_ctrl: RTL

//  Initiator side of the ALU interface: accepts 32-bit instruction words (valid/ready) and decodes them.

---
 rtl/cpu_pkg.sv | 63 ++++++
 rtl/issue_regfile.sv | 44 ++++
 rtl/alu_issue_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage of the simple CPU.
// Purpose: opcode encoding (mirrors the opcode.vh *_OP values), instruction
//          field positions, the issue FSM state type and small decode helpers.
// Ports:   none (package).
package cpu_pkg;

    // 4-bit opcode carried in instr[31:28]; 14 and 15 are unassigned.
    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_MUL   = 4'd2,
        OP_DIV   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_LW    = 4'd7,
        OP_SW    = 4'd8,
        OP_JMP   = 4'd9,
        OP_BEQ   = 4'd10,
        OP_BGT   = 4'd11,
        OP_BLT   = 4'd12,
        OP_LI    = 4'd13,
        OP_ILL14 = 4'd14,
        OP_ILL15 = 4'd15
    } opcode_e;

    // Instruction word layout: [31:28]op [27:24]rd [23:20]rs1 [19:16]rs2 [15:0]imm16
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RS1_MSB = 23;
    localparam int RS1_LSB = 20;
    localparam int RS2_MSB = 19;
    localparam int RS2_LSB = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MEM  = 2'd2,
        RET  = 2'd3
    } state_e;

    // Register-register operations executed by the ALU itself.
    function automatic logic is_alu_class(input opcode_e op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR};
    endfunction

    function automatic logic is_mem(input opcode_e op);
        return op inside {OP_LW, OP_SW};
    endfunction

    function automatic logic is_branch(input opcode_e op);
        return op inside {OP_JMP, OP_BEQ, OP_BGT, OP_BLT};
    endfunction

    function automatic logic is_illegal(input opcode_e op);
        return op inside {OP_ILL14, OP_ILL15};
    endfunction

endpackage

// File: rtl/issue_regfile.sv
// Register file for the execute stage.
// Purpose: NREGS x DATAWIDTH storage, r0 hard-wired to zero, two combinational
//          operand read ports, one combinational debug read port, one
//          synchronous write port and a synchronous active-low clear.
// Ports:   clk, rst (sync, active-low clear of all registers)
//          rd_addr_a/rd_data_a, rd_addr_b/rd_data_b : operand reads
//          dbg_addr/dbg_data                         : debug read
//          wr_en/wr_addr/wr_data                     : write port
module issue_regfile #(
    parameter int DATAWIDTH = 32,
    parameter int NREGS     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] rd_addr_a,
    output logic [DATAWIDTH-1:0]     rd_data_a,
    input  logic [$clog2(NREGS)-1:0] rd_addr_b,
    output logic [DATAWIDTH-1:0]     rd_data_b,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [DATAWIDTH-1:0]     dbg_data,
    input  logic                     wr_en,
    input  logic [$clog2(NREGS)-1:0] wr_addr,
    input  logic [DATAWIDTH-1:0]     wr_data
);

    logic [DATAWIDTH-1:0] regs [NREGS];

    // Writes to r0 are dropped, so r0 keeps its cleared value of zero forever.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Reads see the pre-write value during the cycle a write is pending.
    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
    assign dbg_data  = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute stage of the simple CPU: initiator side of the ALU interface.
// Purpose: accepts instruction words (valid/ready), decodes them, reads the
//          local register file, drives the external ALU, then performs
//          writeback, the LW/SW memory handshake or branch resolution.
// Ports:   clk, rst (sync, active-low)
//          instr_valid_i/instr_ready_o/instr_i/instr_pc_i : instruction input
//          alu_opcode_o/alu_a_o/alu_b_o/alu_out_i         : ALU pins
//          mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/
//          mem_rdata_i/mem_ack_i                          : memory handshake
//          retire_o/branch_taken_o/branch_target_o/
//          illegal_o/trap_o                               : completion status
//          dbg_addr_i/dbg_data_o                          : debug register read
// Config:  define ALU_ISSUE_DIVZERO_TRAP_EN to trap DIV with rs2==0 instead of
//          writing the ALU result.
module alu_issue_ctrl
    import cpu_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int NREGS     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instr_valid_i,
    output logic                     instr_ready_o,
    input  logic [31:0]              instr_i,
    input  logic [DATAWIDTH-1:0]     instr_pc_i,
    output logic [3:0]               alu_opcode_o,
    output logic [DATAWIDTH-1:0]     alu_a_o,
    output logic [DATAWIDTH-1:0]     alu_b_o,
    input  logic [DATAWIDTH-1:0]     alu_out_i,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [DATAWIDTH-1:0]     mem_addr_o,
    output logic [DATAWIDTH-1:0]     mem_wdata_o,
    input  logic [DATAWIDTH-1:0]     mem_rdata_i,
    input  logic                     mem_ack_i,
    output logic                     retire_o,
    output logic                     branch_taken_o,
    output logic [DATAWIDTH-1:0]     branch_target_o,
    output logic                     illegal_o,
    output logic                     trap_o,
    input  logic [$clog2(NREGS)-1:0] dbg_addr_i,
    output logic [DATAWIDTH-1:0]     dbg_data_o
);

    localparam int AW = $clog2(NREGS);

    state_e               state, state_next;
    opcode_e              dec_op, op_q;
    logic [3:0]           dec_rd, dec_rs1, dec_rs2;
    logic [15:0]          dec_imm;
    logic [DATAWIDTH-1:0] sx_imm, rs1_data, rs2_data, sel_a, sel_b;
    logic [DATAWIDTH-1:0] rs1_q, rs2_q, result_q;
    logic [AW-1:0]        rd_q;
    logic                 taken_q, trap_q, accept, div_zero, branch_cond, wr_en;

    assign dec_op  = opcode_e'(instr_i[OP_MSB:OP_LSB]);
    assign dec_rd  = instr_i[RD_MSB:RD_LSB];
    assign dec_rs1 = instr_i[RS1_MSB:RS1_LSB];
    assign dec_rs2 = instr_i[RS2_MSB:RS2_LSB];
    assign dec_imm = instr_i[IMM_MSB:IMM_LSB];
    assign sx_imm  = {{(DATAWIDTH-16){dec_imm[15]}}, dec_imm};
    assign accept  = instr_valid_i && (state == IDLE);

    issue_regfile #(
        .DATAWIDTH(DATAWIDTH),
        .NREGS    (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rd_addr_a(dec_rs1[AW-1:0]),
        .rd_data_a(rs1_data),
        .rd_addr_b(dec_rs2[AW-1:0]),
        .rd_data_b(rs2_data),
        .dbg_addr (dbg_addr_i),
        .dbg_data (dbg_data_o),
        .wr_en    (wr_en),
        .wr_addr  (rd_q),
        .wr_data  (result_q)
    );

    // Operand selection for the ALU, computed from the offered instruction.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        if (is_alu_class(dec_op)) begin
            sel_a = rs1_data;
            sel_b = rs2_data;
        end else if (is_mem(dec_op)) begin
            sel_a = rs1_data;
            sel_b = sx_imm;
        end else if (is_branch(dec_op)) begin
            sel_a = instr_pc_i;
            sel_b = sx_imm;
        end else if (dec_op == OP_LI) begin
            sel_b = sx_imm;
        end
    end

    // Signed branch comparison on the latched source registers.
    always_comb begin
        branch_cond = 1'b0;
        case (op_q)
            OP_JMP:  branch_cond = 1'b1;
            OP_BEQ:  branch_cond = (rs1_q == rs2_q);
            OP_BGT:  branch_cond = ($signed(rs1_q) > $signed(rs2_q));
            OP_BLT:  branch_cond = ($signed(rs1_q) < $signed(rs2_q));
            default: branch_cond = 1'b0;
        endcase
    end

`ifdef ALU_ISSUE_DIVZERO_TRAP_EN
    assign div_zero = (op_q == OP_DIV) && (rs2_q == '0);
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and all status/memory outputs, decoded from the current state.
    always_comb begin
        state_next      = state;
        instr_ready_o   = (state == IDLE);
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        mem_addr_o      = '0;
        mem_wdata_o     = '0;
        retire_o        = 1'b0;
        branch_taken_o  = 1'b0;
        branch_target_o = '0;
        illegal_o       = 1'b0;
        trap_o          = 1'b0;
        wr_en           = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = is_illegal(dec_op) ? RET : EXEC;
                end
            end
            EXEC: begin
                if (div_zero) begin
                    state_next = RET;
                end else if (is_mem(op_q)) begin
                    state_next = MEM;
                end else begin
                    state_next = RET;
                end
            end
            MEM: begin
                mem_req_o   = 1'b1;
                mem_we_o    = (op_q == OP_SW);
                mem_addr_o  = result_q;
                mem_wdata_o = (op_q == OP_SW) ? rs2_q : '0;
                if (mem_ack_i) begin
                    state_next = RET;
                end
            end
            RET: begin
                state_next      = IDLE;
                retire_o        = 1'b1;
                branch_taken_o  = taken_q;
                branch_target_o = taken_q ? result_q : '0;
                illegal_o       = is_illegal(op_q);
                trap_o          = trap_q;
                wr_en           = !trap_q &&
                                  (is_alu_class(op_q) || op_q == OP_LI || op_q == OP_LW);
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch the decoded instruction on accept, the ALU result at the
    // end of EXEC and the load data on the memory acknowledge.
    // Memory and branch address generation reuse the ALU as an adder.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q         <= OP_ADD;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            result_q     <= '0;
            taken_q      <= 1'b0;
            trap_q       <= 1'b0;
            alu_opcode_o <= '0;
            alu_a_o      <= '0;
            alu_b_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= dec_op;
                        rd_q    <= dec_rd[AW-1:0];
                        rs1_q   <= rs1_data;
                        rs2_q   <= rs2_data;
                        taken_q <= 1'b0;
                        trap_q  <= 1'b0;
                        if (!is_illegal(dec_op)) begin
                            alu_opcode_o <= is_alu_class(dec_op) ? dec_op : OP_ADD;
                            alu_a_o      <= sel_a;
                            alu_b_o      <= sel_b;
                        end
                    end
                end
                EXEC: begin
                    result_q <= alu_out_i;
                    taken_q  <= branch_cond;
                    trap_q   <= div_zero;
                end
                MEM: begin
                    if (mem_ack_i && op_q == OP_LW) begin
                        result_q <= mem_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
